// File: rtl/fft64_input_buffer.sv
// rtl/fft64_input_buffer.sv - ping-pong serial-to-parallel frame buffer feeding the first FFT stage
// Two banks: one fills from the sample stream while the other holds a complete frame for the consumer.
module fft64_input_buffer #(
  parameter int WIDTH = 16,
  parameter int N     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_re,
  input  logic [WIDTH-1:0]   in_im,
  input  logic               in_sop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH*N-1:0] out_re,
  output logic [WIDTH*N-1:0] out_im,
  output logic               frame_err
);

  localparam int IDXW = $clog2(N);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;

  bank_st_t                  st_q [2];
  bank_st_t                  st_d [2];
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [IDXW-1:0]           widx_q, widx_d;
  logic [IDXW-1:0]           wsel;
  logic [1:0][WIDTH*N-1:0]   re_q, re_d;
  logic [1:0][WIDTH*N-1:0]   im_q, im_d;
  logic                      frame_err_q, frame_err_d;
  logic                      accept;
  logic                      consume;

  assign in_ready  = (st_q[wr_bank_q] != FULL);
  assign out_valid = (st_q[rd_bank_q] == FULL);
  assign out_re    = re_q[rd_bank_q];
  assign out_im    = im_q[rd_bank_q];
  assign frame_err = frame_err_q;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  // An in_sop sample always lands at index 0, restarting the frame in place.
  assign wsel = in_sop ? '0 : widx_q;

  always_comb begin
    st_d[0]     = st_q[0];
    st_d[1]     = st_q[1];
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    widx_d      = widx_q;
    re_d        = re_q;
    im_d        = im_q;
    frame_err_d = 1'b0;

    // Read and write banks differ whenever both fire, so these updates never collide.
    if (consume) begin
      st_d[rd_bank_q] = EMPTY;
      rd_bank_d       = ~rd_bank_q;
    end

    if (accept) begin
      frame_err_d = in_sop && (widx_q != '0);
      for (int n = 0; n < N; n++) begin
        if (wsel == IDXW'(n)) begin
          re_d[wr_bank_q][n*WIDTH +: WIDTH] = in_re;
          im_d[wr_bank_q][n*WIDTH +: WIDTH] = in_im;
        end
      end
      if (wsel == IDXW'(N-1)) begin
        st_d[wr_bank_q] = FULL;
        widx_d          = '0;
        wr_bank_d       = ~wr_bank_q;
      end else begin
        st_d[wr_bank_q] = FILLING;
        widx_d          = wsel + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      widx_q      <= '0;
      re_q        <= '0;
      im_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      st_q[0]     <= st_d[0];
      st_q[1]     <= st_d[1];
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      widx_q      <= widx_d;
      re_q        <= re_d;
      im_q        <= im_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_fft64_input_buffer.sv
// tb/tb_fft64_input_buffer.sv - self-checking bench for fft64_input_buffer
// A frame-queue model predicts handshakes and frame contents; directed tests add literal checks.
module tb_fft64_input_buffer;

  localparam int W  = 16;
  localparam int N  = 64;
  localparam int FW = W * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_re = '0;
  logic [W-1:0]  in_im = '0;
  logic          in_ready;
  logic          out_valid;
  logic          frame_err;
  logic [FW-1:0] out_re;
  logic [FW-1:0] out_im;

  fft64_input_buffer #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_sop    (in_sop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  int handshakes = 0;
  int stalls = 0;

  logic [FW-1:0] mq_re[$];
  logic [FW-1:0] mq_im[$];
  logic [FW-1:0] cur_re, cur_im;
  int            cnt;
  logic          m_err;
  bit            m_acc, m_con;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cmp_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    int bad;
    bad = -1;
    for (int n = N - 1; n >= 0; n--)
      if (act[n*W +: W] !== exp[n*W +: W]) bad = n;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s slice=%0d actual=%0h required=%0h", name, bad, act[bad*W +: W], exp[bad*W +: W]);
    end
  endtask

  // Model: a queue of completed frames (at most two fit) plus the frame being assembled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_re.delete();
      mq_im.delete();
      cnt    = 0;
      m_err  = 1'b0;
      cur_re = '0;
      cur_im = '0;
    end else begin
      m_acc = in_valid && (mq_re.size() < 2);
      m_con = (mq_re.size() > 0) && out_ready;
      m_err = m_acc && in_sop && (cnt != 0);
      if (m_con) begin
        void'(mq_re.pop_front());
        void'(mq_im.pop_front());
        handshakes++;
      end
      if (m_acc) begin
        if (in_sop) cnt = 0;
        cur_re[cnt*W +: W] = in_re;
        cur_im[cnt*W +: W] = in_im;
        cnt++;
        if (cnt == N) begin
          mq_re.push_back(cur_re);
          mq_im.push_back(cur_im);
          cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'b0, in_ready}, {31'b0, mq_re.size() < 2});
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq_re.size() > 0});
    chk("frame_err", {31'b0, frame_err}, {31'b0, m_err});
    if (frame_err === 1'b1) err_pulses++;
    if (out_valid === 1'b1 && mq_re.size() > 0) begin
      cmp_frame("out_re", out_re, mq_re[0]);
      cmp_frame("out_im", out_im, mq_im[0]);
    end
  end

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic sop);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_sop   = sop;
    if (in_ready !== 1'b1) stalls++;
    while (in_ready !== 1'b1 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  initial begin
    int h0, e0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_out_zero", {31'b0, (out_re == '0) && (out_im == '0)}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame A: first half real, second half imaginary.
    out_ready = 1'b1;
    for (int n = 0; n < N; n++)
      send(n < 32 ? 16'h0800 : 16'h0000, n < 32 ? 16'h0000 : 16'h0800, n == 0);
    chk("A_valid", {31'b0, out_valid}, 32'd1);
    chk("A_re0", {16'b0, out_re[0 +: W]}, 32'h0800);
    chk("A_re31", {16'b0, out_re[31*W +: W]}, 32'h0800);
    chk("A_re32", {16'b0, out_re[32*W +: W]}, 32'h0000);
    chk("A_im0", {16'b0, out_im[0 +: W]}, 32'h0000);
    chk("A_im63", {16'b0, out_im[63*W +: W]}, 32'h0800);
    idle();
    @(posedge clk); #1;

    // Two back-to-back ramp frames at full rate.
    h0 = handshakes;
    stalls = 0;
    for (int n = 0; n < 2 * N; n++) begin
      send(W'(n), W'(-n), (n % N) == 0);
      if (n == N - 1) begin
        chk("R0_re10", {16'b0, out_re[10*W +: W]}, 32'h000A);
        chk("R0_im10", {16'b0, out_im[10*W +: W]}, 32'hFFF6);
      end
    end
    chk("R1_re10", {16'b0, out_re[10*W +: W]}, 32'h004A);
    chk("R1_im10", {16'b0, out_im[10*W +: W]}, 32'hFFB6);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("ramp_stalls", stalls, 32'd0);
    chk("ramp_frames", handshakes - h0, 32'd2);

    // Early in_sop after 11 samples restarts the frame.
    e0 = err_pulses;
    send(16'h0100, 16'h0F00, 1'b1);
    for (int k = 1; k <= 10; k++) send(W'(16'h0100 + k), W'(16'h0F00 + k), 1'b0);
    send(16'h0200, 16'h0E00, 1'b1);
    for (int k = 1; k < N; k++) send(W'(16'h0200 + k), W'(16'h0E00 + k), 1'b0);
    chk("sop_valid", {31'b0, out_valid}, 32'd1);
    chk("sop_re0", {16'b0, out_re[0 +: W]}, 32'h0200);
    chk("sop_re10", {16'b0, out_re[10*W +: W]}, 32'h020A);
    chk("sop_im0", {16'b0, out_im[0 +: W]}, 32'h0E00);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("sop_err_pulses", err_pulses - e0, 32'd1);

    // Back-pressure: both banks fill, input stalls, one consume frees a bank.
    out_ready = 1'b0;
    for (int n = 0; n < 2 * N; n++) send(W'(16'h1000 + n), W'(16'h2000 + n), (n % N) == 0);
    in_valid = 1'b1;
    in_re    = 16'h1080;
    in_im    = 16'h2080;
    in_sop   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_hold_re5", {16'b0, out_re[5*W +: W]}, 32'h1005);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_frame1_re0", {16'b0, out_re[0 +: W]}, 32'h1040);
    send(16'h1080, 16'h2080, 1'b1);
    for (int n = 1; n < 30; n++) send(W'(16'h1080 + n), W'(16'h2080 + n), 1'b0);
    idle();

    // Reset with one bank FULL and the other at index 30.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_zero", {31'b0, (out_re == '0) && (out_im == '0)}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < N; n++) send(W'(16'h3000 + n), W'(16'h4000 - n), n == 0);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_re63", {16'b0, out_re[63*W +: W]}, 32'h303F);
    chk("post_rst_im1", {16'b0, out_im[1*W +: W]}, 32'h3FFF);
    idle();
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
